// File: rtl/execute_stage_pkg.sv
// Shared constants for the RV32I execute stage: ALU opcodes, forwarding
// selects and result-source encodings.
package execute_stage_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int REG_ADDR_BITS = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // 2'b11 is reserved and behaves like FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: eight operations, wrap-around arithmetic,
// shifts use only the low five bits of src_b_i.
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic [2:0]       alu_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic [4:0] shamt;
  logic       lt_signed;

  assign shamt     = src_b_i[4:0];
  assign lt_signed = $signed(src_a_i) < $signed(src_b_i);

  // Operation select; default keeps the block latch-free for any encoding.
  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_ADD: result_o = src_a_i + src_b_i;
      ALU_SUB: result_o = src_a_i - src_b_i;
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_XOR: result_o = src_a_i ^ src_b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLL: result_o = src_a_i << shamt;
      ALU_SRL: result_o = src_a_i >> shamt;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump
// redirect and the EX/MEM pipeline register. The memory stage never stalls,
// so the register captures every cycle.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH      = WORD_SIZE,
  parameter int REG_ADDR_W = REG_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      RD1E,
  input  logic [WIDTH-1:0]      RD2E,
  input  logic [WIDTH-1:0]      PCE,
  input  logic [WIDTH-1:0]      PCPlus4E,
  input  logic [WIDTH-1:0]      ImmExtE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic [1:0]            ResultSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [WIDTH-1:0]      ResultW,
  output logic                  PCSrcE,
  output logic [WIDTH-1:0]      PCTargetE,
  output logic [WIDTH-1:0]      ALUResultM,
  output logic [WIDTH-1:0]      WriteDataM,
  output logic [WIDTH-1:0]      PCPlus4M,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM
);

  logic [WIDTH-1:0] src_a_e;
  logic [WIDTH-1:0] write_data_e;
  logic [WIDTH-1:0] src_b_e;
  logic [WIDTH-1:0] alu_result_e;
  logic             zero_e;

  logic [WIDTH-1:0]      alu_result_d, alu_result_q;
  logic [WIDTH-1:0]      write_data_d, write_data_q;
  logic [WIDTH-1:0]      pc_plus4_d,   pc_plus4_q;
  logic [REG_ADDR_W-1:0] rd_d,         rd_q;
  logic                  reg_write_d,  reg_write_q;
  logic                  mem_write_d,  mem_write_q;
  logic [1:0]            result_src_d, result_src_q;

  // Forwarding muxes; FWD_MEM reads the registered result of the previous instruction.
  always_comb begin
    src_a_e      = RD1E;
    write_data_e = RD2E;
    case (ForwardAE)
      FWD_WB:  src_a_e = ResultW;
      FWD_MEM: src_a_e = alu_result_q;
      default: src_a_e = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  write_data_e = ResultW;
      FWD_MEM: write_data_e = alu_result_q;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_b_e = ALUSrcE ? ImmExtE : write_data_e;

  execute_stage_alu #(.WIDTH(WIDTH)) u_alu (
    .src_a_i       (src_a_e),
    .src_b_i       (src_b_e),
    .alu_control_i (ALUControlE),
    .result_o      (alu_result_e),
    .zero_o        (zero_e)
  );

  // Redirect is resolved in EX so the hazard unit can flush D and E this cycle.
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = (BranchE & zero_e) | JumpE;

  // Next-state of the EX/MEM register: straight capture of the E-side values.
  always_comb begin
    alu_result_d = alu_result_e;
    write_data_d = write_data_e;
    pc_plus4_d   = PCPlus4E;
    rd_d         = RdE;
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
  end

  // EX/MEM register; reset discards whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed steps from the plan followed by random
// instructions, all checked against a behavioural model of the EX stage.
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam int W = WORD_SIZE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0]   RdE;
  logic         RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]   ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]   ALUControlE;
  logic         PCSrcE;
  logic [W-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]   RdM;
  logic         RegWriteM, MemWriteM;
  logic [1:0]   ResultSrcM;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];          // expected ALUResultM, one entry per clock
  logic [W-1:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
  logic [4:0]   m_rd = '0;
  logic         m_rw = 1'b0, m_mw = 1'b0;
  logic [1:0]   m_rs = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned ua, ub, t;
    longint sa, sb;
    int sh;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    sh = int'(b % 32);
    case (op)
      3'd0: t = ua + ub;
      3'd1: t = ua + 64'h1_0000_0000 - ub;
      3'd2: t = ua & ub;
      3'd3: t = ua | ub;
      3'd4: t = ua ^ ub;
      3'd5: t = (sa < sb) ? 64'd1 : 64'd0;
      3'd6: t = ua * (64'd1 << sh);
      default: t = ua / (64'd1 << sh);
    endcase
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] regv,
                                        input logic [W-1:0] wb, input logic [W-1:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return regv;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    RD1E = '0; RD2E = '0; PCE = '0; PCPlus4E = '0; ImmExtE = '0; ResultW = '0;
    RdE = '0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = '0; ALUControlE = '0; ForwardAE = '0; ForwardBE = '0;
  endtask

  // One instruction through EX: check redirect, clock, check the M register.
  task automatic step(input string tag);
    logic [W-1:0] a, wd, b, res, tgt;
    logic [64:0] tsum;
    logic taken;
    #1;
    a     = pick(ForwardAE, RD1E, ResultW, m_alu);
    wd    = pick(ForwardBE, RD2E, ResultW, m_alu);
    b     = ALUSrcE ? ImmExtE : wd;
    res   = ref_alu(ALUControlE, a, b);
    tsum  = {33'd0, PCE} + {33'd0, ImmExtE};
    tgt   = tsum[W-1:0];
    taken = (BranchE && res == '0) || JumpE;
    chk({tag, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, taken});
    chk({tag, ".target"}, PCTargetE, tgt);
    exp_q.push_back(rst ? '0 : res);
    if (rst) begin
      m_wd = '0; m_pc4 = '0; m_rd = '0; m_rw = 0; m_mw = 0; m_rs = '0;
    end else begin
      m_wd = wd; m_pc4 = PCPlus4E; m_rd = RdE; m_rw = RegWriteE; m_mw = MemWriteE;
      m_rs = ResultSrcE;
    end
    @(posedge clk);
    #1;
    m_alu = exp_q.pop_front();
    chk({tag, ".alu_m"}, ALUResultM, m_alu);
    chk({tag, ".wdata_m"}, WriteDataM, m_wd);
    chk({tag, ".pc4_m"}, PCPlus4M, m_pc4);
    chk({tag, ".rd_m"}, {27'd0, RdM}, {27'd0, m_rd});
    chk({tag, ".rw_m"}, {31'd0, RegWriteM}, {31'd0, m_rw});
    chk({tag, ".mw_m"}, {31'd0, MemWriteM}, {31'd0, m_mw});
    chk({tag, ".rs_m"}, {30'd0, ResultSrcM}, {30'd0, m_rs});
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_imm);
    clear_inputs();
    ALUControlE = op; RD1E = a; ALUSrcE = use_imm;
    if (use_imm) ImmExtE = b; else RD2E = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    @(negedge clk);

    // Reset for two cycles with nonzero inputs.
    rst = 1;
    RD1E = 32'hDEAD_BEEF; RD2E = 32'h1234; PCPlus4E = 32'h88; RdE = 5'd9;
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10;
    step("reset0");
    step("reset1");
    chk("reset.alu_zero", ALUResultM, 32'd0);
    chk("reset.rw_zero", {31'd0, RegWriteM}, 32'd0);

    // First instruction after reset: add 5 + 7 into x3.
    rst = 0;
    alu_op(3'b000, 32'd5, 32'd7, 0); RegWriteE = 1; RdE = 5'd3;
    step("add");
    chk("add.result12", ALUResultM, 32'd12);
    chk("add.rd3", {27'd0, RdM}, 32'd3);

    // Forwarding: load 0x10, then sub with A from MEM and B from WB.
    alu_op(3'b000, 32'h10, 32'h0, 0);
    step("prior");
    alu_op(3'b001, 32'h999, 32'h777, 0);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20; MemWriteE = 1;
    step("fwd");
    chk("fwd.sub", ALUResultM, 32'hFFFF_FFF0);
    chk("fwd.wdata", WriteDataM, 32'h20);

    // Branch taken / not taken.
    alu_op(3'b001, 32'd9, 32'd9, 0); BranchE = 1; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
    #1;
    chk("beq.taken", {31'd0, PCSrcE}, 32'd1);
    chk("beq.target", PCTargetE, 32'hF8);
    step("beq_t");
    RD2E = 32'd8;
    #1;
    chk("beq.not_taken", {31'd0, PCSrcE}, 32'd0);
    step("beq_nt");

    // JAL, then jump together with a taken branch.
    clear_inputs();
    JumpE = 1; ResultSrcE = 2'b10; PCE = 32'h40; PCPlus4E = 32'h44; ImmExtE = 32'h20;
    RegWriteE = 1; RdE = 5'd1;
    #1;
    chk("jal.pcsrc", {31'd0, PCSrcE}, 32'd1);
    chk("jal.target", PCTargetE, 32'h60);
    step("jal");
    chk("jal.pc4_m", PCPlus4M, 32'h44);
    chk("jal.rs_m", {30'd0, ResultSrcM}, 32'd2);
    BranchE = 1; ALUControlE = 3'b001; ALUSrcE = 0;
    step("jal_br");

    // ALU corners.
    alu_op(3'b101, 32'hFFFF_FFFF, 32'd1, 0); step("slt");
    chk("slt.neg", ALUResultM, 32'd1);
    alu_op(3'b110, 32'd1, 32'h21, 1); step("sll");
    chk("sll.mask", ALUResultM, 32'd2);
    alu_op(3'b111, 32'h8000_0000, 32'd31, 0); step("srl");
    chk("srl.31", ALUResultM, 32'd1);
    alu_op(3'b000, 32'hFFFF_FFFF, 32'd1, 0); step("wrap");
    chk("add.wrap", ALUResultM, 32'd0);

    // Write to x0 still propagates.
    alu_op(3'b011, 32'hF0, 32'h0F, 0); RegWriteE = 1; RdE = 5'd0;
    step("x0");
    chk("x0.rw", {31'd0, RegWriteM}, 32'd1);

    // Load in EX while reset is asserted is discarded.
    alu_op(3'b000, 32'h200, 32'h4, 1); RegWriteE = 1; ResultSrcE = 2'b01; RdE = 5'd7;
    rst = 1;
    step("midrst");
    chk("midrst.rw", {31'd0, RegWriteM}, 32'd0);
    chk("midrst.alu", ALUResultM, 32'd0);
    rst = 0;

    // Random instructions against the model.
    for (int i = 0; i < 60; i++) begin
      RD1E = $urandom; RD2E = $urandom; PCE = $urandom; PCPlus4E = $urandom;
      ImmExtE = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ResultW = $urandom; RdE = 5'($urandom_range(0, 31));
      RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
      JumpE = ($urandom_range(0, 5) == 0); BranchE = 1'($urandom_range(0, 1));
      ALUSrcE = 1'($urandom_range(0, 1)); ResultSrcE = 2'($urandom_range(0, 2));
      ALUControlE = 3'($urandom_range(0, 7));
      ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) RD2E = RD1E;
      rst = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
